// File: rtl/operand_entry.sv
// Keypad operand entry: builds two signed decimal operands from key strobes
// and presents them as a committed pair until downstream acknowledges.
module operand_entry #(
    parameter int WIDTH      = 32,
    parameter int MAX_DIGITS = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_valid,
    input  logic [4:0]       key_code,
    input  logic             consume_ack,
    output logic [WIDTH-1:0] dat1,
    output logic [WIDTH-1:0] dat2,
    output logic             port_select,
    output logic [WIDTH-1:0] entry_value,
    output logic             operands_valid,
    output logic             ovf
);

    // state   | meaning
    // ENTER_A | typing operand 1
    // ENTER_B | typing operand 2
    // READY   | pair committed, waiting for consume_ack
    typedef enum logic [1:0] {
        ENTER_A = 2'd0,
        ENTER_B = 2'd1,
        READY   = 2'd2
    } state_t;

    localparam int         CW        = $clog2(MAX_DIGITS + 1);
    localparam logic [4:0] KEY_ENTER = 5'd10;
    localparam logic [4:0] KEY_CLEAR = 5'd11;
    localparam logic [4:0] KEY_SIGN  = 5'd12;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_acc, w_acc_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic             r_neg, w_neg_nxt;
    logic [WIDTH-1:0] r_dat1, w_dat1_nxt;
    logic [WIDTH-1:0] r_dat2, w_dat2_nxt;
    logic             r_port_select, w_port_select_nxt;
    logic             r_valid, w_valid_nxt;
    logic             r_ovf, w_ovf_nxt;
    logic [WIDTH-1:0] r_entry, w_entry_nxt;
    logic [WIDTH-1:0] w_value;
    logic [WIDTH-1:0] w_digit;
    logic             w_is_digit;
    logic             w_is_clear;

    assign w_value    = r_neg ? (WIDTH'(0) - r_acc) : r_acc;
    assign w_digit    = WIDTH'(key_code);
    assign w_is_digit = (key_code < 5'd10);
    assign w_is_clear = key_valid && (key_code == KEY_CLEAR);

    always_comb begin
        w_state_nxt       = r_state;
        w_acc_nxt         = r_acc;
        w_cnt_nxt         = r_cnt;
        w_neg_nxt         = r_neg;
        w_dat1_nxt        = r_dat1;
        w_dat2_nxt        = r_dat2;
        w_port_select_nxt = r_port_select;
        w_valid_nxt       = r_valid;
        w_ovf_nxt         = r_ovf;

        if (w_is_clear) begin
            w_state_nxt       = ENTER_A;
            w_acc_nxt         = '0;
            w_cnt_nxt         = '0;
            w_neg_nxt         = 1'b0;
            w_dat1_nxt        = '0;
            w_dat2_nxt        = '0;
            w_port_select_nxt = 1'b0;
            w_valid_nxt       = 1'b0;
            w_ovf_nxt         = 1'b0;
        end else begin
            case (r_state)
                ENTER_A, ENTER_B: begin
                    if (key_valid) begin
                        if (w_is_digit) begin
                            // Leading zeros never consume a digit slot.
                            if (r_cnt == CW'(MAX_DIGITS)) begin
                                w_ovf_nxt = 1'b1;
                            end else if (!(r_acc == '0 && key_code == 5'd0)) begin
                                w_acc_nxt = r_acc * WIDTH'(10) + w_digit;
                                w_cnt_nxt = r_cnt + CW'(1);
                            end
                        end else if (key_code == KEY_SIGN) begin
                            w_neg_nxt = ~r_neg;
                        end else if (key_code == KEY_ENTER) begin
                            w_acc_nxt = '0;
                            w_cnt_nxt = '0;
                            w_neg_nxt = 1'b0;
                            if (r_state == ENTER_A) begin
                                w_dat1_nxt        = w_value;
                                w_port_select_nxt = 1'b1;
                                w_state_nxt       = ENTER_B;
                            end else begin
                                w_dat2_nxt  = w_value;
                                w_valid_nxt = 1'b1;
                                w_state_nxt = READY;
                            end
                        end
                    end
                end
                READY: begin
                    if (consume_ack) begin
                        w_valid_nxt       = 1'b0;
                        w_port_select_nxt = 1'b0;
                        w_state_nxt       = ENTER_A;
                    end
                end
                default: w_state_nxt = ENTER_A;
            endcase
        end

        w_entry_nxt = w_neg_nxt ? (WIDTH'(0) - w_acc_nxt) : w_acc_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ENTER_A;
            r_acc         <= '0;
            r_cnt         <= '0;
            r_neg         <= 1'b0;
            r_dat1        <= '0;
            r_dat2        <= '0;
            r_port_select <= 1'b0;
            r_valid       <= 1'b0;
            r_ovf         <= 1'b0;
            r_entry       <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_acc         <= w_acc_nxt;
            r_cnt         <= w_cnt_nxt;
            r_neg         <= w_neg_nxt;
            r_dat1        <= w_dat1_nxt;
            r_dat2        <= w_dat2_nxt;
            r_port_select <= w_port_select_nxt;
            r_valid       <= w_valid_nxt;
            r_ovf         <= w_ovf_nxt;
            r_entry       <= w_entry_nxt;
        end
    end

    assign dat1           = r_dat1;
    assign dat2           = r_dat2;
    assign port_select    = r_port_select;
    assign entry_value    = r_entry;
    assign operands_valid = r_valid;
    assign ovf            = r_ovf;

endmodule

// File: tb/tb_operand_entry.sv
// Bench for operand_entry: directed scenarios then random keys, all compared
// against a digit-list model of the keypad entry rules.
module tb_operand_entry;

    localparam int MAXD = 9;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        key_valid = 1'b0;
    logic [4:0]  key_code = 5'd0;
    logic        consume_ack = 1'b0;
    logic [31:0] dat1, dat2, entry_value;
    logic        port_select, operands_valid, ovf;

    int n_checks = 0;
    int n_fail   = 0;

    operand_entry #(.WIDTH(32), .MAX_DIGITS(MAXD)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .key_valid      (key_valid),
        .key_code       (key_code),
        .consume_ack    (consume_ack),
        .dat1           (dat1),
        .dat2           (dat2),
        .port_select    (port_select),
        .entry_value    (entry_value),
        .operands_valid (operands_valid),
        .ovf            (ovf)
    );

    always #5 clk = ~clk;

    // Model: phase 0 = operand 1, 1 = operand 2, 2 = pair ready.
    int          m_phase;
    int          m_digits[$];
    bit          m_neg;
    logic [31:0] m_dat1, m_dat2;
    bit          m_ps, m_valid, m_ovf;

    function automatic logic [31:0] m_entry();
        logic [31:0] a = 32'd0;
        foreach (m_digits[i]) a = a * 32'd10 + 32'(m_digits[i]);
        return m_neg ? (32'd0 - a) : a;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_digits.delete(); m_neg = 0;
        m_dat1 = 0; m_dat2 = 0; m_ps = 0; m_valid = 0; m_ovf = 0;
    endtask

    task automatic model_step(input bit kv, input int code, input bit ack);
        if (kv && code == 11) begin
            model_reset();
        end else if (m_phase < 2) begin
            if (kv && code < 10) begin
                if (m_digits.size() == MAXD) m_ovf = 1;
                else if (!(m_digits.size() == 0 && code == 0)) m_digits.push_back(code);
            end else if (kv && code == 12) begin
                m_neg = !m_neg;
            end else if (kv && code == 10) begin
                if (m_phase == 0) begin m_dat1 = m_entry(); m_ps = 1; m_phase = 1; end
                else begin m_dat2 = m_entry(); m_valid = 1; m_phase = 2; end
                m_digits.delete(); m_neg = 0;
            end
        end else if (ack) begin
            m_valid = 0; m_ps = 0; m_phase = 0;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string where);
        check({where, ".dat1"}, dat1, m_dat1);
        check({where, ".dat2"}, dat2, m_dat2);
        check({where, ".entry"}, entry_value, m_entry());
        check({where, ".psel"}, 32'(port_select), 32'(m_ps));
        check({where, ".valid"}, 32'(operands_valid), 32'(m_valid));
        check({where, ".ovf"}, 32'(ovf), 32'(m_ovf));
    endtask

    task automatic drive(input string where, input bit kv, input int code, input bit ack);
        @(negedge clk);
        key_valid = kv; key_code = 5'(code); consume_ack = ack;
        @(posedge clk);
        model_step(kv, code, ack);
        #1;
        check_all(where);
        key_valid = 0; consume_ack = 0;
    endtask

    task automatic press(input string where, input int code);
        drive(where, 1'b1, code, 1'b0);
    endtask

    task automatic do_reset(input string where, input bit kv, input int code, input bit ack);
        @(negedge clk);
        rst_n = 0; key_valid = kv; key_code = 5'(code); consume_ack = ack;
        @(posedge clk);
        model_reset();
        #1;
        check_all(where);
        @(negedge clk);
        rst_n = 1; key_valid = 0; consume_ack = 0;
    endtask

    initial begin
        model_reset();
        do_reset("reset", 1'b1, 5, 1'b1);

        // 123 / 987 pair, then consume
        press("r036", 1); press("r036", 2); press("r036", 3); press("r036", 10);
        press("r036", 9); press("r036", 8); press("r036", 7); press("r036", 10);
        check("r036_dat1_const", dat1, 32'd123);
        check("r036_dat2_const", dat2, 32'd987);
        drive("r036_ack", 1'b0, 0, 1'b1);
        check("r036_dat1_held", dat1, 32'd123);

        // negative operand, and double sign restores positive
        press("r037", 4); press("r037", 4); press("r037", 5); press("r037", 12);
        press("r037", 10);
        check("r037_neg", dat1, 32'hFFFFFE43);
        press("r037", 2); press("r037", 2); press("r037", 12); press("r037", 12);
        press("r037", 2); press("r037", 10);
        check("r037_pos", dat2, 32'd222);
        drive("r037_ack", 1'b0, 0, 1'b1);

        // digit overflow, sticky across ENTER
        for (int i = 1; i <= 9; i++) press("r038", i);
        press("r038_extra", 0);
        check("r038_entry_const", entry_value, 32'd123456789);
        press("r038_enter", 10);
        check("r038_ovf_sticky", 32'(ovf), 32'd1);
        press("r038_clear", 11);

        // empty operands, leading zeros (0,0,7 then 8 more digits fit)
        press("r039", 12); press("r039", 10); press("r039", 10);
        drive("r039_ack", 1'b0, 0, 1'b1);
        press("r039", 0); press("r039", 0); press("r039", 7);
        check("r039_entry7", entry_value, 32'd7);
        for (int i = 0; i < 8; i++) press("r039_fill", 1);
        check("r039_no_ovf", 32'(ovf), 32'd0);
        press("r039_ovf", 1);
        press("r039_enter", 10); press("r039", 3); press("r039", 10);

        // READY ignores keys; ack outside READY ignored; CLEAR beats ack
        press("r040_digit", 5); press("r040_sign", 12); press("r040_unused", 20);
        drive("r040_key_ack", 1'b1, 6, 1'b1);
        press("r040", 1); drive("r040_ack_ignored", 1'b0, 0, 1'b1);
        press("r040", 10); press("r040", 10);
        drive("r040_clear_ack", 1'b1, 11, 1'b1);

        // reset mid-entry with ENTER on the same edge
        press("r041", 5); press("r041", 6);
        check("r041_entry56", entry_value, 32'd56);
        do_reset("r041_reset", 1'b1, 10, 1'b0);

        // random keys
        for (int n = 0; n < 600; n++) begin
            int r, code;
            bit kv, ack;
            r = $urandom_range(0, 99);
            if (r < 2) begin
                do_reset("rand_reset", 1'($urandom_range(0, 1)), $urandom_range(0, 31), 1'($urandom_range(0, 1)));
            end else begin
                kv = ($urandom_range(0, 3) != 0);
                r = $urandom_range(0, 99);
                if (r < 68)      code = $urandom_range(0, 9);
                else if (r < 82) code = 10;
                else if (r < 89) code = 12;
                else if (r < 92) code = 11;
                else             code = $urandom_range(13, 31);
                ack = ($urandom_range(0, 4) == 0);
                drive("rand", kv, code, ack);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/operand_entry.md
OPERAND_ENTRY -- requirements
Module: operand_entry

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and data width.
REQ-002 SHALL have parameter MAX_DIGITS, default 9, maximum decimal digits per operand.
REQ-003 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, synchronous active-low reset, sampled on the rising edge of clk.
REQ-005 SHALL have port key_valid, input, 1, one-cycle strobe marking a key press.
REQ-006 SHALL have port key_code, input, 5, key: 0-9 digit, 10 ENTER, 11 CLEAR, 12 SIGN, 13-31 unused.
REQ-007 SHALL have port consume_ack, input, 1, downstream has taken the operand pair.
REQ-008 SHALL have port dat1, output, WIDTH, committed first operand, two's complement.
REQ-009 SHALL have port dat2, output, WIDTH, committed second operand, two's complement.
REQ-010 SHALL have port port_select, output, 1, display/mux select: 0 while entering operand 1, 1 otherwise.
REQ-011 SHALL have port entry_value, output, WIDTH, signed value currently being typed.
REQ-012 SHALL have port operands_valid, output, 1, both operands committed, pair stable.
REQ-013 SHALL have port ovf, output, 1, sticky flag: digit dropped due to MAX_DIGITS limit.

Function
REQ-014 SHALL implement FSM states ENTER_A, ENTER_B, READY; reset state ENTER_A.
REQ-015 SHALL keep internal accumulator acc (unsigned, WIDTH), digit count cnt, and sign flag neg.
REQ-016 SHALL register all outputs; a key strobe at edge N is reflected in outputs after edge N.
REQ-017 SHALL ignore key_code and consume_ack on cycles where their qualifiers are low; key_code is sampled only with key_valid=1.
REQ-018 SHALL, on digit d in ENTER_A/ENTER_B with cnt<MAX_DIGITS: acc<=acc*10+d, cnt<=cnt+1.
REQ-019 SHALL, on digit with cnt==MAX_DIGITS: leave acc/cnt unchanged and set ovf.
REQ-020 SHALL, on leading digit 0 with acc==0: keep acc=0 and not increment cnt.
REQ-021 SHALL, on SIGN in ENTER_A/ENTER_B: toggle neg.
REQ-022 SHALL drive entry_value = neg ? -acc : acc (two's complement, WIDTH bits).
REQ-023 SHALL, on ENTER in ENTER_A: dat1<=entry_value, clear acc/cnt/neg, port_select<=1, go ENTER_B.
REQ-024 SHALL, on ENTER in ENTER_B: dat2<=entry_value, clear acc/cnt/neg, operands_valid<=1, go READY.
REQ-025 SHALL commit 0 on ENTER with no digits entered, regardless of neg.
REQ-026 SHALL, in READY: ignore digit, SIGN, ENTER and unused codes; hold dat1, dat2, port_select=1.
REQ-027 SHALL, on consume_ack in READY: operands_valid<=0, port_select<=0, go ENTER_A; dat1/dat2 retain values.
REQ-028 SHALL ignore consume_ack outside READY.
REQ-029 SHALL, on CLEAR in any state: acc, cnt, neg, dat1, dat2, ovf, operands_valid, port_select <=0, go ENTER_A.
REQ-030 SHALL give CLEAR priority over a simultaneous consume_ack; in READY a non-CLEAR key with consume_ack acts as consume_ack only.
REQ-031 SHALL ignore unused key codes 13-31 in all states with no state change.
REQ-032 SHALL not clear ovf except by CLEAR or reset; ENTER does not clear it.

Reset
REQ-033 SHALL, with rst_n=0 at a rising edge: state ENTER_A; dat1, dat2, entry_value, acc, cnt, neg = 0; port_select, operands_valid, ovf = 0.
REQ-034 SHALL let reset override all inputs including a coincident key_valid or consume_ack, including mid-entry and in READY.
REQ-035 SHALL produce no output change before the first rising edge with rst_n=1.

Verification
REQ-036 Keys 1,2,3,ENTER,9,8,7,ENTER -> dat1=123, dat2=987, port_select=1, operands_valid=1; consume_ack -> valid=0, port_select=0, dat1/dat2 held.
REQ-037 Keys 4,4,5,SIGN,ENTER,2,2,2,ENTER -> dat1=0xFFFFFE43 (-445), dat2=222; SIGN,SIGN before ENTER leaves value positive.
REQ-038 Ten digits 1..9,0 on operand 1 -> entry_value=123456789, ovf=1; ENTER -> dat1=123456789, ovf stays 1 until CLEAR.
REQ-039 ENTER,ENTER with no digits -> dat1=0, dat2=0, operands_valid=1; 0,0,7 -> entry_value=7, cnt=1.
REQ-040 In READY: digit 5 -> no change; CLEAR with consume_ack same cycle -> all outputs 0, state ENTER_A.
REQ-041 rst_n=0 mid-entry (entry_value=56) with key_valid=1, key_code=ENTER -> all outputs 0, dat1 not updated.
